// File: rtl/pong_pkg.sv
// Shared constants, debouncer state encoding and the preset value function
// for the pong speed logic.
package pong_pkg;

   localparam int CLK_HZ           = 50_000_000;
   localparam int DEFAULT_BASE_VAL = 156_250;
   localparam int DEFAULT_STEP_VAL = 100_000;

   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } deb_state_t;

   // Terminal count for preset i. It is evaluated in 64-bit signed arithmetic,
   // which covers any CNT_W up to 61. The result is floored at min_val and
   // saturated at 2^cnt_w-1. Callers truncate the result to CNT_W.
   function automatic logic [63:0] preset_value(
      input longint i,
      input longint base,
      input longint step,
      input longint def_idx,
      input longint min_val,
      input longint cnt_w
   );
      longint v;
      longint max_v;
      v     = base + (def_idx - i) * step;
      max_v = (longint'(1) <<< cnt_w) - 1;
      if (v < min_val)
         v = min_val;
      else if (v > max_v)
         v = max_v;
      return 64'(v);
   endfunction

endpackage

// File: rtl/speed_select_if.sv
// Button and speed bus between the board inputs, the selector and the ball divider.
interface speed_select_if #(
   parameter int NUM_PRESETS = 3,
   parameter int CNT_W       = 32
);
   localparam int PRESET_W = $clog2(NUM_PRESETS);

   logic [NUM_PRESETS-1:0] button_n;
   logic                   hit_pulse;
   logic                   round_reset;
   logic [CNT_W-1:0]       counter_val;
   logic [PRESET_W-1:0]    preset_idx;
   logic                   change_pulse;

   modport master (
      output button_n, hit_pulse, round_reset,
      input  counter_val, preset_idx, change_pulse
   );

   modport slave (
      input  button_n, hit_pulse, round_reset,
      output counter_val, preset_idx, change_pulse
   );
endinterface

// File: rtl/speed_select_debounce.sv
// Per-button 2-flop synchroniser followed by a debounce FSM. It emits a
// single press event once the low level has been stable for
// DEBOUNCE_CYCLES cycles. It also exposes the debounced pressed level.
module button_debounce
   import pong_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic button_n,
   output logic press,
   output logic level
);
   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]  sync_reg;
   logic        sync_n;
   deb_state_t  state;
   logic [CW-1:0] cnt;

   // Bring the raw asynchronous button into the clk domain. The flops reset to released.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         sync_reg <= 2'b11;
      else
         sync_reg <= {sync_reg[0], button_n};
   end

   assign sync_n = sync_reg[1];

   // Debounce FSM. The counter tracks consecutive stable cycles in the wait states.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RELEASED;
         cnt   <= '0;
      end else begin
         case (state)
            RELEASED: begin
               if (!sync_n) begin
                  state <= PRESS_WAIT;
                  cnt   <= '0;
               end
            end
            PRESS_WAIT: begin
               if (sync_n)
                  state <= RELEASED;
               else if (cnt == LAST)
                  state <= PRESSED;
               else
                  cnt <= cnt + 1'b1;
            end
            PRESSED: begin
               if (sync_n) begin
                  state <= RELEASE_WAIT;
                  cnt   <= '0;
               end
            end
            default: begin
               if (!sync_n)
                  state <= PRESSED;
               else if (cnt == LAST)
                  state <= RELEASED;
               else
                  cnt <= cnt + 1'b1;
            end
         endcase
      end
   end

   // The press event is decoded from registered state only. The selector
   // registers it, which keeps the latency at sync + DEBOUNCE_CYCLES + 1.
   assign press = (state == PRESS_WAIT) && !sync_n && (cnt == LAST);
   assign level = (state == PRESSED) || (state == RELEASE_WAIT);

endmodule

// File: rtl/speed_select.sv
// Game-speed selector. It turns debounced active-low speed buttons into a
// registered terminal count for the ball clock divider.
// Optional build macro SPEED_RAMP_EN: each paddle hit speeds the ball up,
// and round_reset restores the selected preset.
module speed_select
   import pong_pkg::*;
#(
   parameter int NUM_PRESETS     = 3,
   parameter int CNT_W           = 32,
   parameter int BASE_VAL        = DEFAULT_BASE_VAL,
   parameter int STEP_VAL        = DEFAULT_STEP_VAL,
   parameter int DEFAULT_IDX     = 1,
   parameter int MIN_VAL         = 20_000,
   parameter int DEBOUNCE_CYCLES = 500_000,
   parameter int RAMP_STEP       = 2_000
) (
   input logic          clk,
   input logic          rst_n,
   speed_select_if.slave bus
);
   localparam int PRESET_W = $clog2(NUM_PRESETS);
   localparam logic [CNT_W-1:0] RESET_VAL = CNT_W'(preset_value(
      longint'(DEFAULT_IDX), longint'(BASE_VAL), longint'(STEP_VAL),
      longint'(DEFAULT_IDX), longint'(MIN_VAL), longint'(CNT_W)));

   logic [NUM_PRESETS-1:0] press;
   logic [NUM_PRESETS-1:0] level_unused;
   logic [CNT_W-1:0]       preset_tbl [NUM_PRESETS];

   logic                   any_press;
   logic [PRESET_W-1:0]    sel_idx;
   logic [PRESET_W-1:0]    preset_idx_reg, preset_idx_next;
   logic [CNT_W-1:0]       counter_val_reg, counter_val_next;
   logic                   change_pulse_reg;

   // One debouncer and one constant preset value for each button.
   generate
      for (genvar gi = 0; gi < NUM_PRESETS; gi++) begin : g_btn
         button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk      (clk),
            .rst_n    (rst_n),
            .button_n (bus.button_n[gi]),
            .press    (press[gi]),
            .level    (level_unused[gi])
         );
         assign preset_tbl[gi] = CNT_W'(preset_value(
            longint'(gi), longint'(BASE_VAL), longint'(STEP_VAL),
            longint'(DEFAULT_IDX), longint'(MIN_VAL), longint'(CNT_W)));
      end
   endgenerate

   // Fastest wins: the highest-index button with an event this cycle is selected.
   always_comb begin
      any_press = 1'b0;
      sel_idx   = '0;
      for (int i = 0; i < NUM_PRESETS; i++) begin
         if (press[i]) begin
            any_press = 1'b1;
            sel_idx   = PRESET_W'(i);
         end
      end
   end

`ifdef SPEED_RAMP_EN
   localparam logic [CNT_W:0]   MIN_PLUS_RAMP = (CNT_W+1)'(MIN_VAL) + (CNT_W+1)'(RAMP_STEP);
   localparam logic [CNT_W-1:0] MIN_C         = CNT_W'(MIN_VAL);
   localparam logic [CNT_W-1:0] RAMP_C        = CNT_W'(RAMP_STEP);

   // Next selection and count. A press beats round_reset, and round_reset beats hit_pulse.
   always_comb begin
      preset_idx_next  = preset_idx_reg;
      counter_val_next = counter_val_reg;
      if (any_press) begin
         preset_idx_next  = sel_idx;
         counter_val_next = preset_tbl[sel_idx];
      end else if (bus.round_reset) begin
         counter_val_next = preset_tbl[preset_idx_reg];
      end else if (bus.hit_pulse) begin
         if ({1'b0, counter_val_reg} < MIN_PLUS_RAMP)
            counter_val_next = MIN_C;
         else
            counter_val_next = counter_val_reg - RAMP_C;
      end
   end
`else
   logic ramp_unused;
   assign ramp_unused = bus.hit_pulse | bus.round_reset;

   // Next selection and count. Only press events move the speed.
   always_comb begin
      preset_idx_next  = preset_idx_reg;
      counter_val_next = counter_val_reg;
      if (any_press) begin
         preset_idx_next  = sel_idx;
         counter_val_next = preset_tbl[sel_idx];
      end
   end
`endif

   // Register the selection. The pulse fires only when the count really changes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         preset_idx_reg   <= PRESET_W'(DEFAULT_IDX);
         counter_val_reg  <= RESET_VAL;
         change_pulse_reg <= 1'b0;
      end else begin
         preset_idx_reg   <= preset_idx_next;
         counter_val_reg  <= counter_val_next;
         change_pulse_reg <= (counter_val_next != counter_val_reg);
      end
   end

   assign bus.counter_val  = counter_val_reg;
   assign bus.preset_idx   = preset_idx_reg;
   assign bus.change_pulse = change_pulse_reg;

endmodule

// File: tb/tb_speed_select.sv
// Testbench for speed_select (DEBOUNCE_CYCLES=4). Each expected speed change
// is queued when the stimulus is driven. The queue entry is popped on every
// change_pulse.
module tb_speed_select;
   localparam int NP = 3;
   localparam int CW = 32;

   typedef struct {
      logic [31:0] val;
      logic [1:0]  idx;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks_total = 0;
   int   checks_passed = 0;
   exp_t exp_q[$];
   logic [31:0] cur_val;

   speed_select_if #(.NUM_PRESETS(NP), .CNT_W(CW)) bus ();

   speed_select #(.NUM_PRESETS(NP), .CNT_W(CW), .DEBOUNCE_CYCLES(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
      checks_total++;
      if (got !== want)
         $display("FAIL %s: got %0d expected %0d", tag, got, want);
      else begin
         checks_passed++;
         $display("ok   %s: %0d", tag, got);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [31:0] v, input logic [1:0] i);
      exp_t e;
      e.val = v;
      e.idx = i;
      exp_q.push_back(e);
   endtask

   // Hold the buttons in mask low for hold cycles. Then release them and let
   // the release debounce complete.
   task automatic press_btn(input logic [NP-1:0] mask, input int hold);
      bus.button_n = ~mask;
      tick(hold);
      bus.button_n = '1;
      tick(10);
   endtask

   task automatic pulse(input logic hit, input logic rr);
      bus.hit_pulse   = hit;
      bus.round_reset = rr;
      tick(1);
      bus.hit_pulse   = 1'b0;
      bus.round_reset = 1'b0;
      tick(1);
   endtask

   // Scoreboard: every change_pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst_n && bus.change_pulse) begin
         if (exp_q.size() == 0) begin
            check_val("pulse_unexpected", 64'(bus.change_pulse), 64'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check_val("sb_counter_val", 64'(bus.counter_val), 64'(e.val));
            check_val("sb_preset_idx", 64'(bus.preset_idx), 64'(e.idx));
         end
      end
   end

   initial begin
      bus.button_n    = '1;
      bus.hit_pulse   = 1'b0;
      bus.round_reset = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(1);

      // 1. Reset state
      check_val("reset_counter", 64'(bus.counter_val), 64'd156250);
      check_val("reset_idx", 64'(bus.preset_idx), 64'd1);
      check_val("reset_pulse", 64'(bus.change_pulse), 64'd0);
      tick(10);
      check_val("idle_counter", 64'(bus.counter_val), 64'd156250);

      // 2. Latency of a press on button 2, then a press on button 0
      push_exp(32'd56250, 2'd2);
      bus.button_n = 3'b011;
      tick(6);
      check_val("latency_before", 64'(bus.counter_val), 64'd156250);
      tick(1);
      check_val("latency_at7", 64'(bus.counter_val), 64'd56250);
      check_val("latency_idx", 64'(bus.preset_idx), 64'd2);
      tick(13);
      bus.button_n = '1;
      tick(10);
      push_exp(32'd256250, 2'd0);
      press_btn(3'b001, 12);
      check_val("btn0_counter", 64'(bus.counter_val), 64'd256250);

      // 3. A 3-cycle glitch is ignored. Five bounces then a steady low give one update.
      bus.button_n = 3'b101;
      tick(3);
      bus.button_n = '1;
      tick(10);
      check_val("glitch_counter", 64'(bus.counter_val), 64'd256250);
      push_exp(32'd156250, 2'd1);
      for (int b = 0; b < 5; b++) begin
         bus.button_n = 3'b101;
         tick(1);
         bus.button_n = '1;
         tick(1);
      end
      press_btn(3'b010, 12);
      check_val("bounce_counter", 64'(bus.counter_val), 64'd156250);

      // 4. A simultaneous press selects the fastest preset. Re-selecting it gives no pulse.
      push_exp(32'd56250, 2'd2);
      press_btn(3'b101, 12);
      check_val("simul_counter", 64'(bus.counter_val), 64'd56250);
      check_val("simul_idx", 64'(bus.preset_idx), 64'd2);
      press_btn(3'b100, 12);
      check_val("reselect_counter", 64'(bus.counter_val), 64'd56250);

      // 5. Reset in the middle of PRESS_WAIT
      bus.button_n = 3'b101;
      tick(4);
      rst_n = 1'b0;
      #1;
      check_val("midrst_counter", 64'(bus.counter_val), 64'd156250);
      check_val("midrst_idx", 64'(bus.preset_idx), 64'd1);
      bus.button_n = '1;
      tick(2);
      rst_n = 1'b1;
      tick(15);
      check_val("postrst_counter", 64'(bus.counter_val), 64'd156250);
      check_val("postrst_idx", 64'(bus.preset_idx), 64'd1);

      // 6. Paddle-hit ramp on preset 2
      push_exp(32'd56250, 2'd2);
      press_btn(3'b100, 12);
      cur_val = 32'd56250;
`ifdef SPEED_RAMP_EN
      for (int h = 0; h < 3; h++) begin
         cur_val = cur_val - 32'd2000;
         push_exp(cur_val, 2'd2);
         pulse(1'b1, 1'b0);
      end
      check_val("ramp3_counter", 64'(bus.counter_val), 64'd50250);
      for (int h = 0; h < 30; h++) begin
         logic [31:0] nv;
         nv = (cur_val < 32'd22000) ? 32'd20000 : cur_val - 32'd2000;
         if (nv != cur_val)
            push_exp(nv, 2'd2);
         cur_val = nv;
         pulse(1'b1, 1'b0);
      end
      check_val("ramp_floor", 64'(bus.counter_val), 64'd20000);
      push_exp(32'd56250, 2'd2);
      pulse(1'b0, 1'b1);
      check_val("round_reset", 64'(bus.counter_val), 64'd56250);
      push_exp(32'd54250, 2'd2);
      pulse(1'b1, 1'b0);
      push_exp(32'd56250, 2'd2);
      pulse(1'b1, 1'b1);
      check_val("rr_over_hit", 64'(bus.counter_val), 64'd56250);
      check_val("ramp_idx", 64'(bus.preset_idx), 64'd2);
`else
      for (int h = 0; h < 3; h++)
         pulse(1'b1, 1'b0);
      pulse(1'b0, 1'b1);
      pulse(1'b1, 1'b1);
      check_val("hits_ignored", 64'(bus.counter_val), 64'(cur_val));
      check_val("hits_idx", 64'(bus.preset_idx), 64'd2);
`endif
      tick(5);
      check_val("sb_drain", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
